// File: rtl/regfile_writeback_if.sv
// regfile_writeback_if
//   Bundles the writeback-side signals of regfile_writeback so the block is
//   connected through a single port.
//   Producer handshakes : mem_valid/mem_rd/mem_data/mem_ready,
//                         alu_valid/alu_rd/alu_data/alu_ready
//   Regfile write port  : regWrite/write_reg/write_data
//   Forwarding lookups  : fwd_reg1/fwd_reg2 in, fwd_hit*/fwd_data* out
//   Status              : pending (queue occupancy)
//   Modports: master = environment side (drives results and lookups),
//             slave  = regfile_writeback.
interface regfile_writeback_if #(
  parameter int WORD   = 64,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 3
);
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_rd;
  logic [WORD-1:0]   mem_data;
  logic              mem_ready;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [WORD-1:0]   alu_data;
  logic              alu_ready;
  logic              regWrite;
  logic [ADDR_W-1:0] write_reg;
  logic [WORD-1:0]   write_data;
  logic [ADDR_W-1:0] fwd_reg1;
  logic [ADDR_W-1:0] fwd_reg2;
  logic              fwd_hit1;
  logic [WORD-1:0]   fwd_data1;
  logic              fwd_hit2;
  logic [WORD-1:0]   fwd_data2;
  logic [CNT_W-1:0]  pending;

  modport master (
    output mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data,
    output fwd_reg1, fwd_reg2,
    input  mem_ready, alu_ready, regWrite, write_reg, write_data,
    input  fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, pending
  );

  modport slave (
    input  mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data,
    input  fwd_reg1, fwd_reg2,
    output mem_ready, alu_ready, regWrite, write_reg, write_data,
    output fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, pending
  );
endinterface

// File: rtl/regfile_writeback.sv
// regfile_writeback
//   Write-side driver for the regfile write port. Load and ALU results are
//   queued in acceptance order (load before ALU when both arrive together),
//   drained one per cycle into registered regWrite/write_reg/write_data, and
//   exposed to decode through two combinational forwarding lookups.
//   Ports: clk, rst_n (async, active low), bus (regfile_writeback_if.slave).
module regfile_writeback #(
  parameter int WORD   = 64,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  regfile_writeback_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] XZR     = {ADDR_W{1'b1}};
  localparam logic [CNT_W-1:0]  LIM_ONE = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  LIM_TWO = CNT_W'(DEPTH - 2);

  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [ADDR_W-1:0] rd_q   [DEPTH];
  logic [ADDR_W-1:0] rd_d   [DEPTH];
  logic [WORD-1:0]   data_q [DEPTH];
  logic [WORD-1:0]   data_d [DEPTH];
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_reg_q, wr_reg_d;
  logic [WORD-1:0]   wr_data_q, wr_data_d;

  logic              mem_ready_s, alu_ready_s;
  logic              mem_push_s, alu_push_s, pop_s;
  logic [PTR_W-1:0]  alu_slot_s;
  logic [WORD:0]     fwd1_s, fwd2_s;

  // Youngest pending value for idx: {hit, data}. The output register is the
  // oldest candidate, then queue entries from head (oldest) to tail (youngest),
  // so a later match overrides an earlier one.
  function automatic logic [WORD:0] fwd_lookup(input logic [ADDR_W-1:0] idx);
    logic             hit;
    logic [WORD-1:0]  val;
    logic [PTR_W-1:0] slot;
    hit = 1'b0;
    val = {WORD{1'b0}};
    if (idx != XZR) begin
      if (wr_en_q && (wr_reg_q == idx)) begin
        hit = 1'b1;
        val = wr_data_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        slot = head_q + PTR_W'(i);
        if ((CNT_W'(i) < count_q) && (rd_q[slot] == idx)) begin
          hit = 1'b1;
          val = data_q[slot];
        end
      end
    end
    return {hit, val};
  endfunction

  // Readies look only at the registered occupancy; a slot freed by this
  // edge's pop is deliberately not reused, keeping ready off the pop path.
  always_comb begin
    mem_ready_s = (count_q <= LIM_ONE);
    if (bus.mem_valid) begin
      alu_ready_s = (count_q <= LIM_TWO);
    end else begin
      alu_ready_s = (count_q <= LIM_ONE);
    end
    // XZR results are consumed by the handshake but never occupy a slot.
    mem_push_s = bus.mem_valid & mem_ready_s & (bus.mem_rd != XZR);
    alu_push_s = bus.alu_valid & alu_ready_s & (bus.alu_rd != XZR);
    pop_s      = (count_q != {CNT_W{1'b0}});
    alu_slot_s = mem_push_s ? (tail_q + PTR_W'(1)) : tail_q;
  end

  // Queue next state: pop head into the output register, push mem then ALU.
  always_comb begin
    rd_d      = rd_q;
    data_d    = data_q;
    head_d    = head_q;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    if (pop_s) begin
      wr_en_d   = 1'b1;
      wr_reg_d  = rd_q[head_q];
      wr_data_d = data_q[head_q];
      head_d    = head_q + PTR_W'(1);
    end else begin
      // Empty queue: drop the enable, hold the last index/data.
      wr_en_d = 1'b0;
    end
    if (mem_push_s) begin
      rd_d[tail_q]   = bus.mem_rd;
      data_d[tail_q] = bus.mem_data;
    end else begin
      rd_d[tail_q]   = rd_d[tail_q];
    end
    if (alu_push_s) begin
      rd_d[alu_slot_s]   = bus.alu_rd;
      data_d[alu_slot_s] = bus.alu_data;
    end else begin
      rd_d[alu_slot_s]   = rd_d[alu_slot_s];
    end
    tail_d  = tail_q + PTR_W'(mem_push_s) + PTR_W'(alu_push_s);
    count_d = count_q + CNT_W'(mem_push_s) + CNT_W'(alu_push_s) - CNT_W'(pop_s);
  end

  // State registers; reset discards every pending entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= {CNT_W{1'b0}};
      head_q    <= {PTR_W{1'b0}};
      tail_q    <= {PTR_W{1'b0}};
      wr_en_q   <= 1'b0;
      wr_reg_q  <= {ADDR_W{1'b0}};
      wr_data_q <= {WORD{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= {ADDR_W{1'b0}};
        data_q[i] <= {WORD{1'b0}};
      end
    end else begin
      count_q   <= count_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      wr_en_q   <= wr_en_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
    end
  end

  // Forwarding lookups for both decode read ports.
  always_comb begin
    fwd1_s = fwd_lookup(bus.fwd_reg1);
    fwd2_s = fwd_lookup(bus.fwd_reg2);
  end

  assign bus.mem_ready  = mem_ready_s;
  assign bus.alu_ready  = alu_ready_s;
  assign bus.regWrite   = wr_en_q;
  assign bus.write_reg  = wr_reg_q;
  assign bus.write_data = wr_data_q;
  assign bus.pending    = count_q;
  assign bus.fwd_hit1   = fwd1_s[WORD];
  assign bus.fwd_data1  = fwd1_s[WORD-1:0];
  assign bus.fwd_hit2   = fwd2_s[WORD];
  assign bus.fwd_data2  = fwd2_s[WORD-1:0];
endmodule
